select_encode_seq: RTL and testbench
====================================

Name: select_encode_seq

Overview:
- Parametrised select-and-encode unit with a built-in operand micro-sequencer.
- Latches the instruction word and decodes the ra/rb/rc fields to one-hot register-file in/out enables.
- Sign-extends the C immediate onto the bus.
- Manual mode: the control unit drives gra/grb/grc directly, cycle by cycle.
- Auto mode: a start strobe walks a read-B / read-C-or-immediate / write-A sequence without control-unit involvement.

Parameters:
- DATA_W, 32, instruction and bus width.
- NUM_REGS, 16, number of general registers (2..2**RSEL_W).
- RSEL_W, 4, width of each register field.
- OPC_W, 5, opcode field width.
- IMM_W, 19, C immediate field width (bits IMM_W-1:0 of IR).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ir_in  in  DATA_W  instruction from bus.
- ir_load  in  1  latch ir_in into internal IR.
- gra, grb, grc  in  1  manual field selects.
- r_in, r_out, ba_out  in  1  manual enable qualifiers.
- start  in  1  begin auto sequence (one-cycle strobe).
- mode  in  2  auto sequence type.
- hold  in  1  stretch current auto state.
- reg_in_en  out  NUM_REGS  one-hot register load enables.
- reg_out_en  out  NUM_REGS  one-hot register bus-drive enables.
- ba_sel  out  1  selected read is base-address (R0 reads as zero).
- c_out_en  out  1  c_sign is driving the bus.
- c_sign  out  DATA_W  sign-extended C field.
- opcode  out  OPC_W  IR[DATA_W-1 -: OPC_W].
- busy  out  1  auto sequence active.
- done  out  1  one-cycle pulse at sequence end.
- bad_reg  out  1  sticky; a selected field was >= NUM_REGS.

Behaviour:
- Field layout:
  - opcode below the MSB.
  - ra = next RSEL_W bits, then rb, then rc.
  - C = IR[IMM_W-1:0].
- c_sign = {(DATA_W-IMM_W){IR[IMM_W-1]}, IR[IMM_W-1:0]}. It is combinational from IR and always valid.
- Reset (async, rst_n=0):
  - IR=0, FSM=IDLE.
  - All enables, busy, done and bad_reg = 0.
  - c_sign and opcode = 0 (follow IR).
- ir_load: IR updates at the clock edge when state is IDLE. It is ignored while busy.
- Manual mode, state IDLE:
  - Field select = ra if gra, else rb if grb, else rc if grc (priority ra > rb > rc).
  - No select asserted gives all enables 0.
  - reg_in_en = onehot(field) & r_in.
  - reg_out_en = onehot(field) & (r_out | ba_out).
  - ba_sel = ba_out.
  - All manual outputs are combinational, zero latency.
- Auto mode is Moore: outputs are decoded from the state register and IR only. Manual inputs are ignored while busy.
- States: IDLE, RD_B, RD_C, C_OUT, RD_A, WR_A, FIN.
- Transitions:
  - IDLE + start:
    - mode 0 -> RD_B (three-operand).
    - mode 1 -> RD_B with ba_sel=1 (base+immediate).
    - mode 2 -> RD_A (read-only, e.g. store data / branch).
    - mode 3 -> WR_A (write-only, e.g. load).
  - mode 0: RD_B -> RD_C -> WR_A.
  - mode 1: RD_B -> C_OUT -> WR_A.
  - mode 2: RD_A -> FIN.
  - mode 3: WR_A -> FIN.
  - WR_A -> FIN; FIN -> IDLE.
- hold=1 in any non-IDLE, non-FIN state keeps the state, and its outputs remain asserted.
- State outputs:
  - RD_B: reg_out_en = onehot(rb).
  - RD_C: reg_out_en = onehot(rc).
  - RD_A: reg_out_en = onehot(ra).
  - C_OUT: c_out_en = 1.
  - WR_A: reg_in_en = onehot(ra).
  - FIN: done = 1.
- busy = 1 in every state except IDLE.
- start and ir_load in the same IDLE cycle: the IR loads and the sequence begins next cycle using the new IR.
- start while busy is ignored.
- Field value >= NUM_REGS:
  - That one-hot is all zeros.
  - bad_reg is set on the next edge whenever such a field is actively selected (manual or auto).
  - bad_reg clears only on reset.
- Reset asserted mid-sequence aborts immediately to IDLE with all outputs 0. No done pulse is produced.

Test Plan:
- Manual decode: ir_load 0x19AB8000 (opc 3, ra 3, rb 5, rc 7).
  - grb+r_out -> reg_out_en=0x0020.
  - gra+r_in -> reg_in_en=0x0008.
  - gra+grc+r_out -> 0x0008 (priority).
- Auto mode 0, same IR, start at cycle 0:
  - cycle1 out=0x0020, cycle2 out=0x0080, cycle3 in=0x0008, cycle4 done=1.
  - busy high cycles 1-4.
- Auto mode 1: IR 0x6127FFFF.
  - RD_B out=0x0010 with ba_sel=1.
  - C_OUT c_sign=0xFFFFFFFF, c_out_en=1.
  - WR_A in=0x0004.
  - IR 0x6123FFFF gives c_sign=0x0003FFFF.
- hold for 2 cycles in RD_C -> out=0x0080 for 3 cycles; done 2 cycles later than unheld.
  - start and ir_load mid-sequence -> ignored; IR unchanged.
- rst_n low during WR_A -> enables 0 immediately, busy 0, no done pulse.
  - After release, start runs normally.
- NUM_REGS=12, rb=13, manual grb+r_out -> reg_out_en=0, bad_reg=1 next edge and stays 1 until reset.

Source files
------------

// File: rtl/select_encode_seq.sv
// Select-and-encode unit with an operand micro-sequencer.
// Holds the instruction register and decodes its ra/rb/rc fields into
// one-hot register-file enables. The enables come either from the
// control unit's manual gra/grb/grc selects (combinational, IDLE only)
// or from a small Moore sequencer started by a one-cycle strobe.
// c_sign carries the sign-extended C immediate at all times.
module select_encode_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int RSEL_W   = 4,
  parameter int OPC_W    = 5,
  parameter int IMM_W    = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                ir_load,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                r_in,
  input  logic                r_out,
  input  logic                ba_out,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                hold,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic                ba_sel,
  output logic                c_out_en,
  output logic [DATA_W-1:0]   c_sign,
  output logic [OPC_W-1:0]    opcode,
  output logic                busy,
  output logic                done,
  output logic                bad_reg
);

  // Field positions: opcode at the top, then ra, rb, rc going downwards.
  localparam int RA_LSB = DATA_W - OPC_W - RSEL_W;
  localparam int RB_LSB = RA_LSB - RSEL_W;
  localparam int RC_LSB = RB_LSB - RSEL_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_B  = 3'd1;
  localparam logic [2:0] S_RD_C  = 3'd2;
  localparam logic [2:0] S_C_OUT = 3'd3;
  localparam logic [2:0] S_RD_A  = 3'd4;
  localparam logic [2:0] S_WR_A  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [DATA_W-1:0] ir_r;
  logic [2:0]        state_r;
  logic [2:0]        state_nx_s;
  logic [1:0]        mode_r;
  logic [RSEL_W-1:0] ra_s;
  logic [RSEL_W-1:0] rb_s;
  logic [RSEL_W-1:0] rc_s;
  logic [RSEL_W-1:0] man_field_s;
  logic              man_valid_s;
  logic [RSEL_W-1:0] act_field_s;
  logic              act_valid_s;

  // One-hot decode of a register field; values beyond the register file
  // decode to all zeros so no register is ever touched by them.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [RSEL_W-1:0] f);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (f == RSEL_W'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  assign ra_s   = ir_r[RA_LSB +: RSEL_W];
  assign rb_s   = ir_r[RB_LSB +: RSEL_W];
  assign rc_s   = ir_r[RC_LSB +: RSEL_W];
  assign opcode = ir_r[DATA_W-1 -: OPC_W];
  assign c_sign = {{(DATA_W-IMM_W){ir_r[IMM_W-1]}}, ir_r[IMM_W-1:0]};
  assign busy   = (state_r != S_IDLE);

  // Manual field priority: ra over rb over rc.
  assign man_valid_s = gra | grb | grc;
  assign man_field_s = gra ? ra_s : (grb ? rb_s : rc_s);

  // Instruction register: only reloadable while the sequencer is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r <= '0;
    end else if (ir_load && (state_r == S_IDLE)) begin
      ir_r <= ir_in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Sequencer state and the sequence type captured at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      mode_r  <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      if ((state_r == S_IDLE) && start) begin
        mode_r <= mode;
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Next-state logic; hold freezes every working state except FIN.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          case (mode)
            2'd0:    state_nx_s = S_RD_B;
            2'd1:    state_nx_s = S_RD_B;
            2'd2:    state_nx_s = S_RD_A;
            2'd3:    state_nx_s = S_WR_A;
            default: state_nx_s = S_IDLE;
          endcase
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RD_B: begin
        if (hold) begin
          state_nx_s = S_RD_B;
        end else if (mode_r == 2'd1) begin
          state_nx_s = S_C_OUT;
        end else begin
          state_nx_s = S_RD_C;
        end
      end
      S_RD_C:  state_nx_s = hold ? S_RD_C : S_WR_A;
      S_C_OUT: state_nx_s = hold ? S_C_OUT : S_WR_A;
      S_RD_A:  state_nx_s = hold ? S_RD_A : S_FIN;
      S_WR_A:  state_nx_s = hold ? S_WR_A : S_FIN;
      S_FIN:   state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Output decode: manual selects in IDLE, pure state decode otherwise.
  always_comb begin
    reg_in_en   = '0;
    reg_out_en  = '0;
    ba_sel      = 1'b0;
    c_out_en    = 1'b0;
    done        = 1'b0;
    act_valid_s = 1'b0;
    act_field_s = ra_s;
    case (state_r)
      S_IDLE: begin
        ba_sel = ba_out;
        if (man_valid_s) begin
          reg_in_en   = onehot(man_field_s) & {NUM_REGS{r_in}};
          reg_out_en  = onehot(man_field_s) & {NUM_REGS{r_out | ba_out}};
          act_valid_s = 1'b1;
          act_field_s = man_field_s;
        end else begin
          act_valid_s = 1'b0;
        end
      end
      S_RD_B: begin
        reg_out_en  = onehot(rb_s);
        ba_sel      = (mode_r == 2'd1);
        act_valid_s = 1'b1;
        act_field_s = rb_s;
      end
      S_RD_C: begin
        reg_out_en  = onehot(rc_s);
        act_valid_s = 1'b1;
        act_field_s = rc_s;
      end
      S_C_OUT: c_out_en = 1'b1;
      S_RD_A: begin
        reg_out_en  = onehot(ra_s);
        act_valid_s = 1'b1;
        act_field_s = ra_s;
      end
      S_WR_A: begin
        reg_in_en   = onehot(ra_s);
        act_valid_s = 1'b1;
        act_field_s = ra_s;
      end
      S_FIN:   done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // Sticky flag: an out-of-range field was selected at some point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_reg <= 1'b0;
    end else if (act_valid_s && (onehot(act_field_s) == '0)) begin
      bad_reg <= 1'b1;
    end else begin
      bad_reg <= bad_reg;
    end
  end

endmodule

// File: tb/tb_select_encode_seq.sv
// Directed bench for select_encode_seq: manual decode, the four auto
// sequences, hold, ignored start/ir_load while busy, mid-sequence reset,
// and the out-of-range register flag on a 12-register instance.
module tb_select_encode_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir_in;
  logic        ir_load, gra, grb, grc, r_in, r_out, ba_out, start, hold;
  logic [1:0]  mode;
  logic [15:0] reg_in_en, reg_out_en;
  logic        ba_sel, c_out_en, busy, done, bad_reg;
  logic [31:0] c_sign;
  logic [4:0]  opcode;

  logic [31:0] ir_in12;
  logic        ir_load12, grb12, r_out12;
  logic [11:0] reg_in_en12, reg_out_en12;
  logic        ba_sel12, c_out_en12, busy12, done12, bad_reg12;
  logic [31:0] c_sign12;
  logic [4:0]  opcode12;

  int n_cmp;
  int n_fail;

  select_encode_seq dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .ir_load(ir_load),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
    .ba_out(ba_out), .start(start), .mode(mode), .hold(hold),
    .reg_in_en(reg_in_en), .reg_out_en(reg_out_en), .ba_sel(ba_sel),
    .c_out_en(c_out_en), .c_sign(c_sign), .opcode(opcode), .busy(busy),
    .done(done), .bad_reg(bad_reg)
  );

  select_encode_seq #(.NUM_REGS(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in12), .ir_load(ir_load12),
    .gra(1'b0), .grb(grb12), .grc(1'b0), .r_in(1'b0), .r_out(r_out12),
    .ba_out(1'b0), .start(1'b0), .mode(2'd0), .hold(1'b0),
    .reg_in_en(reg_in_en12), .reg_out_en(reg_out_en12), .ba_sel(ba_sel12),
    .c_out_en(c_out_en12), .c_sign(c_sign12), .opcode(opcode12),
    .busy(busy12), .done(done12), .bad_reg(bad_reg12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; ir_in = 32'h0; ir_load = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
    ba_out = 1'b0; start = 1'b0; mode = 2'd0; hold = 1'b0;
    ir_in12 = 32'h0; ir_load12 = 1'b0; grb12 = 1'b0; r_out12 = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_in", reg_in_en, 16'h0);
    chk("rst_out", reg_out_en, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bad", bad_reg, 1'b0);
    chk("rst_csign", c_sign, 32'h0);
    chk("rst_opc", opcode, 5'd0);
    rst_n = 1'b1;
    tick();

    // Manual decode of 0x19AB8000: opc 3, ra 3, rb 5, rc 7
    ir_in = 32'h19AB8000; ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("man_opc", opcode, 5'd3);
    chk("man_csign", c_sign, 32'h00038000);
    grb = 1'b1; r_out = 1'b1; #1;
    chk("man_rb_out", reg_out_en, 16'h0020);
    chk("man_rb_in", reg_in_en, 16'h0000);
    grb = 1'b0; r_out = 1'b0; gra = 1'b1; r_in = 1'b1; #1;
    chk("man_ra_in", reg_in_en, 16'h0008);
    chk("man_ra_out", reg_out_en, 16'h0000);
    r_in = 1'b0; grc = 1'b1; r_out = 1'b1; #1;
    chk("man_prio", reg_out_en, 16'h0008);
    gra = 1'b0; grc = 1'b0; r_out = 1'b0; grb = 1'b1; ba_out = 1'b1; #1;
    chk("man_ba_out", reg_out_en, 16'h0020);
    chk("man_ba_sel", ba_sel, 1'b1);
    grb = 1'b0; ba_out = 1'b0; #1;
    chk("man_none", reg_out_en, 16'h0000);

    // Auto mode 0
    mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    gra = 1'b1; r_in = 1'b1; #1;
    chk("m0_c1_out", reg_out_en, 16'h0020);
    chk("m0_c1_in_ignored", reg_in_en, 16'h0000);
    chk("m0_c1_busy", busy, 1'b1);
    chk("m0_c1_ba", ba_sel, 1'b0);
    gra = 1'b0; r_in = 1'b0;
    tick();
    chk("m0_c2_out", reg_out_en, 16'h0080);
    chk("m0_c2_busy", busy, 1'b1);
    tick();
    chk("m0_c3_in", reg_in_en, 16'h0008);
    chk("m0_c3_out", reg_out_en, 16'h0000);
    tick();
    chk("m0_c4_done", done, 1'b1);
    chk("m0_c4_busy", busy, 1'b1);
    tick();
    chk("m0_c5_done", done, 1'b0);
    chk("m0_c5_busy", busy, 1'b0);

    // Auto mode 1 with ir_load and start in the same cycle
    ir_in = 32'h6127FFFF; ir_load = 1'b1; mode = 2'd1; start = 1'b1;
    tick();
    ir_load = 1'b0; start = 1'b0;
    chk("m1_rdb_out", reg_out_en, 16'h0010);
    chk("m1_rdb_ba", ba_sel, 1'b1);
    chk("m1_opc", opcode, 5'd12);
    tick();
    chk("m1_cout_en", c_out_en, 1'b1);
    chk("m1_cout_sign", c_sign, 32'hFFFFFFFF);
    chk("m1_cout_out", reg_out_en, 16'h0000);
    tick();
    chk("m1_wra_in", reg_in_en, 16'h0004);
    chk("m1_wra_cen", c_out_en, 1'b0);
    tick();
    chk("m1_done", done, 1'b1);
    tick();
    ir_in = 32'h6123FFFF; ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("csign_pos", c_sign, 32'h0003FFFF);

    // Hold in RD_C, with start/ir_load attempts while busy
    ir_in = 32'h19AB8000; ir_load = 1'b1; mode = 2'd0; start = 1'b1;
    tick();
    ir_load = 1'b0; start = 1'b0;
    chk("h_c1_out", reg_out_en, 16'h0020);
    tick();
    chk("h_c2_out", reg_out_en, 16'h0080);
    hold = 1'b1; start = 1'b1; mode = 2'd3; ir_load = 1'b1; ir_in = 32'hFFFFFFFF;
    tick();
    chk("h_c3_out", reg_out_en, 16'h0080);
    chk("h_c3_done", done, 1'b0);
    tick();
    chk("h_c4_out", reg_out_en, 16'h0080);
    chk("h_c4_done", done, 1'b0);
    hold = 1'b0; start = 1'b0; ir_load = 1'b0; mode = 2'd0;
    tick();
    chk("h_c5_in", reg_in_en, 16'h0008);
    chk("h_ir_kept", opcode, 5'd3);
    chk("h_csign_kept", c_sign, 32'h00038000);
    tick();
    chk("h_c6_done", done, 1'b1);
    tick();
    chk("h_c7_idle", busy, 1'b0);

    // Out-of-range rb on the 12-register instance (rb = 13)
    ir_in12 = 32'h00680000; ir_load12 = 1'b1;
    tick();
    ir_load12 = 1'b0;
    chk("bad_before", bad_reg12, 1'b0);
    grb12 = 1'b1; r_out12 = 1'b1; #1;
    chk("bad_out_zero", reg_out_en12, 12'h000);
    tick();
    grb12 = 1'b0; r_out12 = 1'b0;
    chk("bad_set", bad_reg12, 1'b1);
    tick(); tick();
    chk("bad_sticky", bad_reg12, 1'b1);

    // Reset during WR_A (mode 3)
    mode = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rw_wra_in", reg_in_en, 16'h0008);
    chk("rw_wra_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_in_zero", reg_in_en, 16'h0000);
    chk("rw_busy_zero", busy, 1'b0);
    chk("rw_done_zero", done, 1'b0);
    chk("bad_cleared", bad_reg12, 1'b0);
    tick();
    chk("rw_no_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rw_idle_done", done, 1'b0);

    // Normal run after reset: mode 2 reads ra
    ir_in = 32'h19AB8000; ir_load = 1'b1; mode = 2'd2; start = 1'b1;
    tick();
    ir_load = 1'b0; start = 1'b0;
    chk("m2_rda_out", reg_out_en, 16'h0008);
    chk("m2_rda_busy", busy, 1'b1);
    tick();
    chk("m2_done", done, 1'b1);
    tick();
    chk("m2_idle", busy, 1'b0);
    chk("m2_done_low", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
